// File: rtl/bram_table_reader.sv
// bram_table_reader: phase-accumulator read master for a 1-cycle-latency table RAM; issue->valid 2 clk,
// 2-entry output buffer stalls reads under backpressure. `BRAM_TABLE_LOAD_EN adds a table write port.
module bram_table_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [PHASE_W-1:0] phase_init,
  input  logic               phase_load,
  output logic [ADDR_W-1:0]  raddr,
  output logic               read_en,
  output logic               rclke,
  input  logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               idle,
`ifdef BRAM_TABLE_LOAD_EN
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
`endif
  output logic [ADDR_W-1:0]  waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               write_en,
  output logic               wclke,
  output logic [DATA_W-1:0]  mask
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase;
  logic               inflight;
  logic [1:0]         count;
  logic [DATA_W-1:0]  head, tail;
  logic               run_req, push, pop, issue, pending;
  logic [1:0]         used;

`ifdef BRAM_TABLE_LOAD_EN
  logic load_fire;

  // A pending load blocks reads so the FSM drains back to IDLE, where loads are taken.
  assign run_req    = enable && !load_valid;
  assign load_ready = !rst && (state == S_IDLE);
  assign load_fire  = load_valid && load_ready;
  assign write_en   = load_fire;
  assign wclke      = load_fire;
  assign waddr      = load_addr;
  assign wdata      = load_data;
  assign mask       = '0;
`else
  assign run_req  = enable;
  assign write_en = 1'b0;
  assign wclke    = 1'b0;
  assign waddr    = '0;
  assign wdata    = '0;
  assign mask     = '1;
`endif

  assign pop     = sample_valid && sample_ready;
  assign push    = inflight && !phase_load;
  assign pending = (count != 2'd0) || inflight;

  // A slot being popped this cycle counts as free, which is what sustains 1 sample/clk.
  assign used  = count + {1'b0, inflight} - {1'b0, pop};
  assign issue = !rst && run_req && !phase_load && (used < 2'd2);

  assign read_en      = issue;
  assign rclke        = issue;
  assign raddr        = phase[PHASE_W-1 -: ADDR_W];
  assign sample_valid = (count != 2'd0);
  assign sample_data  = head;
  assign idle         = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= issue;
      if (phase_load) begin
        phase <= phase_init;
        count <= 2'd0;
      end else begin
        if (issue) phase <= phase + phase_inc;
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) begin
          if (count == 2'd2) begin
            head <= tail;
            if (push) tail <= rdata;
          end else if (push) begin
            head <= rdata;
          end
        end else if (push) begin
          if (count == 2'd0) head <= rdata;
          else               tail <= rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run_req) state_nxt = S_RUN;
      S_RUN:   if (!run_req) state_nxt = pending ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (run_req)       state_nxt = S_RUN;
        else if (!pending) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_table_reader.sv
// Bench for bram_table_reader: RAM model plus a phase-arithmetic reference for addresses and samples.
module tb_bram_table_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] phase_inc, phase_init;
  logic        phase_load;
  logic [7:0]  raddr;
  logic        read_en, rclke;
  logic [15:0] rdata;
  logic [15:0] sample_data;
  logic        sample_valid, sample_ready;
  logic        idle;
  logic [7:0]  waddr;
  logic [15:0] wdata, mask;
  logic        write_en, wclke;
`ifdef BRAM_TABLE_LOAD_EN
  logic        load_valid, load_ready;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
`endif

  bram_table_reader dut (
    .clk(clk), .rst(rst), .enable(enable),
    .phase_inc(phase_inc), .phase_init(phase_init), .phase_load(phase_load),
    .raddr(raddr), .read_en(read_en), .rclke(rclke), .rdata(rdata),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .idle(idle),
`ifdef BRAM_TABLE_LOAD_EN
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
`endif
    .waddr(waddr), .wdata(wdata), .write_en(write_en), .wclke(wclke), .mask(mask)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = 16'(3 * k);

  always @(posedge clk) begin
    if (read_en) rdata <= mem[raddr];
    if (write_en && wclke) mem[waddr] <= (mem[waddr] & mask) | (wdata & ~mask);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the k-th read of a segment targets (init + k*inc)[15:8]; the k-th accepted
  // sample is the table word at that address.
  logic [15:0] seg_init, seg_inc, prev_dat;
  logic [15:0] seg_first [2];
  int n_iss, n_acc, tot_iss, tot_acc, cyc, first_iss, first_val;
  bit prev_stall;

  initial begin
    tot_iss = 0; tot_acc = 0; cyc = 0;
  end

  task automatic reset_seg(input logic [15:0] init, input logic [15:0] inc);
    seg_init = init; seg_inc = inc;
    n_iss = 0; n_acc = 0; first_iss = -1; first_val = -1;
    seg_first[0] = 16'hDEAD; seg_first[1] = 16'hDEAD;
    prev_stall = 1'b0;
  endtask

  function automatic logic [7:0] exp_addr(input int k);
    logic [31:0] t;
    t = 32'(seg_init) + 32'(k) * 32'(seg_inc);
    return t[15:8];
  endfunction

  function automatic logic [15:0] exp_at(input int k);
    return mem[exp_addr(k)];
  endfunction

  always @(posedge rst) reset_seg(16'h0000, phase_inc);

  always begin
    @(negedge clk); #2;
    cyc++;
    if (rst) begin
      reset_seg(16'h0000, phase_inc);
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(sample_valid), 1);
        check_eq("hold_data", 32'(sample_data), 32'(prev_dat));
      end
      if (sample_valid && first_val < 0) first_val = cyc;
      if (sample_valid && sample_ready) begin
        check_eq("sample", 32'(sample_data), 32'(exp_at(n_acc)));
        if (n_acc < 2) seg_first[n_acc] = sample_data;
        n_acc++; tot_acc++;
      end
      if (phase_load) begin
        check_eq("load_no_issue", 32'(read_en), 0);
      end else if (read_en) begin
        check_eq("raddr", 32'(raddr), 32'(exp_addr(n_iss)));
        check_eq("rclke", 32'(rclke), 1);
        if (first_iss < 0) first_iss = cyc;
        n_iss++; tot_iss++;
        check_eq("outstanding", 32'(n_iss - n_acc <= 2), 1);
      end
      prev_stall = sample_valid && !sample_ready && !phase_load;
      prev_dat   = sample_data;
      if (phase_load) reset_seg(phase_init, phase_inc);
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic do_load(input logic [15:0] init, input logic [15:0] inc);
    phase_init = init; phase_inc = inc; phase_load = 1'b1;
    @(negedge clk);
    phase_load = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (n_acc < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("wait_acc", 32'(n_acc >= n), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int v, i0, p0, k;
    rst = 1'b1; enable = 1'b0; phase_inc = 16'h0100; phase_init = 16'h0000;
    phase_load = 1'b0; sample_ready = 1'b0;
`ifdef BRAM_TABLE_LOAD_EN
    load_valid = 1'b0; load_addr = 8'h00; load_data = 16'h0000;
`endif
    repeat (2) @(negedge clk);
    #3;
    check_eq("rst_raddr", 32'(raddr), 0);
    check_eq("rst_read_en", 32'(read_en), 0);
    check_eq("rst_rclke", 32'(rclke), 0);
    check_eq("rst_valid", 32'(sample_valid), 0);
    check_eq("rst_data", 32'(sample_data), 0);
    check_eq("rst_idle", 32'(idle), 1);
    @(negedge clk);
    rst = 1'b0;

    // Straight stream from phase 0.
    sample_ready = 1'b1;
    do_load(16'h0000, 16'h0100);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("latency", 32'(first_val - first_iss), 2);
    check_eq("first_s0", 32'(seg_first[0]), 32'h0000);
    check_eq("first_s1", 32'(seg_first[1]), 32'h0003);
    p0 = tot_acc;
    repeat (16) @(negedge clk);
    check_eq("throughput", 32'(tot_acc - p0), 16);

    // Stall mid-stream.
    sample_ready = 1'b0;
    i0 = tot_iss; v = 0;
    repeat (10) begin
      #3;
      if (sample_valid) v++;
      @(negedge clk);
    end
    sample_ready = 1'b1;
    check_eq("stall_valid", 32'(v), 10);
    check_eq("stall_issue", 32'(tot_iss - i0), 0);
    repeat (10) @(negedge clk);

    // Address wrap.
    do_load(16'hFF00, 16'h0100);
    wait_acc(2);
    check_eq("wrap_s0", 32'(seg_first[0]), 32'h02FD);
    check_eq("wrap_s1", 32'(seg_first[1]), 32'h0000);

    // Reload while a read is in flight and the buffer holds data.
    sample_ready = 1'b0;
    do_load(16'h1000, 16'h0100);
    repeat (2) @(negedge clk);
    check_eq("pre_flush_iss", 32'(n_iss), 2);
    do_load(16'h4000, 16'h0100);
    sample_ready = 1'b1;
    #3;
    check_eq("flush_valid", 32'(sample_valid), 0);
    @(negedge clk);
    wait_acc(1);
    check_eq("reload_s0", 32'(seg_first[0]), 32'h00C0);

    // Async reset mid-stream.
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_read_en", 32'(read_en), 0);
    check_eq("arst_valid", 32'(sample_valid), 0);
    check_eq("arst_raddr", 32'(raddr), 0);
    check_eq("arst_data", 32'(sample_data), 0);
    check_eq("arst_idle", 32'(idle), 1);
    @(negedge clk);
    rst = 1'b0;
    wait_acc(1);
    check_eq("restart_s0", 32'(seg_first[0]), 0);

    // Random segments with random enable and backpressure.
    for (int s = 0; s < 8; s++) begin
      do_load(16'($urandom), 16'($urandom_range(1, 65535)));
      repeat (60) begin
        enable       = ($urandom_range(0, 7) != 0);
        sample_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
      end
    end

    // Drain to idle.
    enable = 1'b0; sample_ready = 1'b1;
    k = 0;
    while (!idle && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_idle", 32'(idle), 1);
    #3;
    check_eq("drain_valid", 32'(sample_valid), 0);
    @(negedge clk);

`ifdef BRAM_TABLE_LOAD_EN
    load_valid = 1'b1; load_addr = 8'd5; load_data = 16'hBEEF;
    #3;
    check_eq("load_ready_idle", 32'(load_ready), 1);
    check_eq("load_we", 32'(write_en), 1);
    check_eq("load_wclke", 32'(wclke), 1);
    check_eq("load_waddr", 32'(waddr), 5);
    check_eq("load_wdata", 32'(wdata), 32'hBEEF);
    check_eq("load_mask", 32'(mask), 0);
    @(negedge clk);
    load_valid = 1'b0;
    do_load(16'h0500, 16'h0100);
    enable = 1'b1;
    wait_acc(1);
    check_eq("loaded_s0", 32'(seg_first[0]), 32'hBEEF);
    #3;
    check_eq("load_ready_run", 32'(load_ready), 0);
    @(negedge clk);
`else
    check_eq("const_we", 32'(write_en), 0);
    check_eq("const_wclke", 32'(wclke), 0);
    check_eq("const_waddr", 32'(waddr), 0);
    check_eq("const_wdata", 32'(wdata), 0);
    check_eq("const_mask", 32'(mask), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
